// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock through a carry register,
// producing a WIDTH-bit result, carry out and signed overflow after WIDTH/CHUNK cycles.
module serial_chunk_adder #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BaseW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic [BaseW-1:0] base;
    logic [CHUNK:0]   sum;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        out_d       = out_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        base = BaseW'(idx_q * CHUNK);
        sum  = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_q};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                    a_d         = in1;
                    b_d         = sub ? ~in2 : in2;
                    carry_d     = sub;
                    idx_d       = '0;
                    out_d       = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                out_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d              = sum[CHUNK];
                idx_d                = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    idx_d       = '0;
                    carry_out_d = sum[CHUNK];
                    overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (sum[CHUNK-1] != a_q[WIDTH-1]);
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            out_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out       = out_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench for serial_chunk_adder: a 16/4 instance for directed corner cases
// and a default 1024/32 instance for the wide-operand and random vectors.
module tb_serial_chunk_adder;

    localparam int unsigned SW = 16;
    localparam int unsigned SN = 4;
    localparam int unsigned LW = 1024;
    localparam int unsigned LN = 32;

    typedef struct {
        logic [LW-1:0] o;
        logic          c;
        logic          v;
        longint        cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_start = 1'b0, s_sub = 1'b0;
    logic [SW-1:0] s_in1 = '0, s_in2 = '0, s_out;
    logic          s_co, s_ov, s_busy, s_done;
    logic          l_start = 1'b0, l_sub = 1'b0;
    logic [LW-1:0] l_in1 = '0, l_in2 = '0, l_out;
    logic          l_co, l_ov, l_busy, l_done;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   q_s[$];
    exp_t   q_l[$];
    exp_t   last_s, last_l;
    int     bcnt_s = 0, bcnt_l = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_chunk_adder #(.WIDTH(SW), .CHUNK(4)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .in1(s_in1), .in2(s_in2),
        .out(s_out), .carry_out(s_co), .overflow(s_ov), .busy(s_busy), .done(s_done)
    );

    serial_chunk_adder u_large (
        .clk(clk), .rst(rst), .start(l_start), .sub(l_sub), .in1(l_in1), .in2(l_in2),
        .out(l_out), .carry_out(l_co), .overflow(l_ov), .busy(l_busy), .done(l_done)
    );

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: wide integer arithmetic, overflow from operand/result signs.
    function automatic exp_t model(logic [LW-1:0] a, logic [LW-1:0] b, bit s, int w);
        exp_t         m;
        logic [LW:0]  mask, bb, full;
        logic         sa, sb, so;
        mask    = '0;
        mask[w] = 1'b1;
        mask    = mask - 1;
        bb      = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
        full    = ({1'b0, a} & mask) + bb + {{LW{1'b0}}, s};
        m.o     = full[LW-1:0] & mask[LW-1:0];
        m.c     = full[w];
        sa      = a[w-1];
        sb      = b[w-1];
        so      = full[w-1];
        m.v     = s ? (sa != sb && so != sa) : (sa == sb && so != sa);
        m.cyc   = 0;
        return m;
    endfunction

    function automatic logic [LW-1:0] rnd_wide();
        logic [LW-1:0] r;
        for (int k = 0; k < int'(LW / 32); k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int qsize(bit big);
        return big ? q_l.size() : q_s.size();
    endfunction

    task automatic mon(bit big);
        exp_t          e;
        logic [LW-1:0] o;
        logic          dn, bz, c, v;
        int            n;
        string         p;
        p  = big ? "l" : "s";
        dn = big ? l_done : s_done;
        bz = big ? l_busy : s_busy;
        o  = big ? l_out : LW'(s_out);
        c  = big ? l_co : s_co;
        v  = big ? l_ov : s_ov;
        n  = big ? int'(LN) : int'(SN);
        if (rst) begin
            if (big) bcnt_l = 0; else bcnt_s = 0;
            return;
        end
        if (bz) begin
            if (big) bcnt_l++; else bcnt_s++;
        end
        if (dn) begin
            if (qsize(big) == 0) begin
                check({p, "_spurious_done"}, 256'(dn), 256'(0));
            end else begin
                if (big) e = q_l.pop_front(); else e = q_s.pop_front();
                for (int k = 0; k < (big ? 4 : 1); k++)
                    check($sformatf("%s_out%0d", p, k), o[k*256 +: 256], e.o[k*256 +: 256]);
                check({p, "_carry_out"}, 256'(c), 256'(e.c));
                check({p, "_overflow"}, 256'(v), 256'(e.v));
                check({p, "_done_latency"}, 256'(cyc), 256'(e.cyc));
                check({p, "_busy_cycles"}, 256'(big ? bcnt_l : bcnt_s), 256'(n));
                if (big) begin last_l = e; bcnt_l = 0; end
                else begin last_s = e; bcnt_s = 0; end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0);
        mon(1'b1);
    end

    task automatic wait_idle(bit big);
        int            i = 0;
        string         p;
        logic [LW-1:0] o;
        p = big ? "l" : "s";
        while (qsize(big) != 0 && i < 200) begin
            @(negedge clk); #1;
            i++;
        end
        if (qsize(big) != 0) begin
            check({p, "_done_timeout"}, 256'(qsize(big)), 256'(0));
            if (big) q_l.delete(); else q_s.delete();
        end
        @(negedge clk); #1;
        o = big ? l_out : LW'(s_out);
        check({p, "_hold_out"}, 256'(o === (big ? last_l.o : last_s.o)), 256'(1));
        check({p, "_idle_busy_done"}, big ? 256'({l_busy, l_done}) : 256'({s_busy, s_done}),
              256'(0));
    endtask

    task automatic run_op(bit big, logic [LW-1:0] a, logic [LW-1:0] b, bit s,
                          bit known, logic [LW-1:0] ko, bit kc, bit kv, bit wt);
        exp_t e;
        @(negedge clk);
        if (big) begin
            l_start = 1'b1; l_in1 = a; l_in2 = b; l_sub = s;
        end else begin
            s_start = 1'b1; s_in1 = a[SW-1:0]; s_in2 = b[SW-1:0]; s_sub = s;
        end
        @(posedge clk); #1;
        e = model(a, b, s, big ? int'(LW) : int'(SW));
        if (known) begin
            e.o = ko; e.c = kc; e.v = kv;
        end
        e.cyc = cyc + (big ? LN : SN);
        // Scramble operands after acceptance; the result must not depend on them.
        if (big) begin
            l_start = 1'b0; l_in1 = rnd_wide(); l_in2 = rnd_wide(); l_sub = ~s;
            q_l.push_back(e);
        end else begin
            s_start = 1'b0; s_in1 = SW'($urandom); s_in2 = SW'($urandom); s_sub = ~s;
            q_s.push_back(e);
        end
        if (wt) wait_idle(big);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_s_out", 256'(s_out), 256'(0));
        check("rst_s_flags", 256'({s_co, s_ov, s_busy, s_done}), 256'(0));
        check("rst_l_out", l_out[255:0], 256'(0));
        check("rst_l_flags", 256'({l_co, l_ov, l_busy, l_done}), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, 'hFFFF, 'h0001, 1'b0, 1'b1, 'h0000, 1'b1, 1'b0, 1'b1);
        run_op(1'b0, 'h0005, 'h0007, 1'b1, 1'b1, 'hFFFE, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 'h0007, 'h0005, 1'b1, 1'b1, 'h0002, 1'b1, 1'b0, 1'b1);
        run_op(1'b0, 'h7FFF, 'h0001, 1'b0, 1'b1, 'h8000, 1'b0, 1'b1, 1'b1);
        run_op(1'b0, 'h8000, 'h0001, 1'b1, 1'b1, 'h7FFF, 1'b1, 1'b1, 1'b1);

        // start pulses during RUN and during the DONE cycle must both be ignored
        run_op(1'b0, 'h1234, 'h1111, 1'b0, 1'b1, 'h2345, 1'b0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        s_start = 1'b1; s_in1 = 16'hFFFF; s_in2 = 16'hFFFF; s_sub = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_done) break;
        end
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        wait_idle(1'b0);

        // asynchronous reset in the middle of a run: outputs clear, no done follows
        run_op(1'b0, 'h1234, 'h4321, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        q_s.delete();
        #1;
        check("midrst_s_out", 256'(s_out), 256'(0));
        check("midrst_s_flags", 256'({s_co, s_ov, s_busy, s_done}), 256'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        last_s.o = '0;
        repeat (8) @(negedge clk);
        run_op(1'b0, 'h0001, 'h0001, 1'b0, 1'b1, 'h0002, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++)
            run_op(1'b0, LW'($urandom), LW'($urandom), 1'($urandom_range(0, 1)),
                   1'b0, '0, 1'b0, 1'b0, 1'b1);

        run_op(1'b1, '1, 'h1, 1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++)
            run_op(1'b1, rnd_wide(), rnd_wide(), 1'($urandom_range(0, 1)),
                   1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 1024: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 32: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1: request a new operation, sampled on the clk rising edge.
REQ-006 SHALL have port sub  input  1: 0 = add, 1 = subtract (in1 - in2); sampled with start.
REQ-007 SHALL have port in1  input  WIDTH: first operand, sampled with start.
REQ-008 SHALL have port in2  input  WIDTH: second operand, sampled with start.
REQ-009 SHALL have port out  output  WIDTH: result register.
REQ-010 SHALL have port carry_out  output  1: carry out of bit WIDTH-1 (for subtract, 1 = no borrow).
REQ-011 SHALL have port overflow  output  1: two's-complement signed overflow of the completed operation.
REQ-012 SHALL have port busy  output  1: high while chunks are being processed.
REQ-013 SHALL have port done  output  1: one-cycle pulse marking a valid result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at an edge, SHALL latch in1, in2 (inverted when sub=1) and sub into internal registers, set carry register = sub, set chunk index = 0, and enter RUN.
REQ-016 Start acceptance in IDLE SHALL clear out, carry_out and overflow to 0.
REQ-017 In RUN, each edge SHALL compute chunk k = a[k] + b[k] + carry over CHUNK bits, write it to out[k*CHUNK +: CHUNK], update carry, and increment k.
REQ-018 After the edge processing chunk N-1, SHALL enter DONE with done=1, carry_out = final carry, and overflow = (a_msb == b_msb) && (out_msb != a_msb), where b is the possibly inverted operand.
REQ-019 done SHALL rise exactly N cycles after the accepting edge and stay high for exactly one cycle; DONE SHALL return to IDLE at the next edge.
REQ-020 busy SHALL be 1 exactly while in RUN (N cycles) and 0 otherwise.
REQ-021 start SHALL be ignored in RUN and DONE: no relatch, no effect on the running operation, no extra done.
REQ-022 Operand inputs SHALL have no effect after acceptance; changing them in RUN SHALL NOT alter the result.
REQ-023 out, carry_out and overflow SHALL hold their values from done until the next accepted start.
REQ-024 During RUN, out SHALL show partially written chunks; they are valid only from the done cycle onward.
REQ-025 CHUNK == WIDTH (N=1) SHALL give a one-cycle RUN; CHUNK == 1 SHALL give bit-serial operation, N = WIDTH cycles.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH, with carry propagated between chunks through the carry register only.

Reset
REQ-027 While rst=1, SHALL immediately force FSM=IDLE, out=0, carry_out=0, overflow=0, busy=0, done=0, chunk index=0 and carry register=0, independent of clk.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse.
REQ-029 After rst deasserts, SHALL accept the first start normally.

Verification (WIDTH=16, CHUNK=4 unless stated; N=4)
REQ-030 Add wrap: in1=0xFFFF, in2=0x0001, sub=0 -> done 4 cycles after start, out=0x0000, carry_out=1, overflow=0.
REQ-031 Subtract with borrow: in1=0x0005, in2=0x0007, sub=1 -> out=0xFFFE, carry_out=0, overflow=0; then in1=0x0007, in2=0x0005 -> out=0x0002, carry_out=1.
REQ-032 Signed overflow: in1=0x7FFF, in2=0x0001, sub=0 -> out=0x8000, carry_out=0, overflow=1; in1=0x8000, in2=0x0001, sub=1 -> out=0x7FFF, overflow=1.
REQ-033 Ignored start: start an add of 0x1234+0x1111, then assert start with 0xFFFF, 0xFFFF in RUN cycle 2 -> single done, out=0x2345, busy high for exactly 4 cycles.
REQ-034 Reset mid-operation: assert rst in RUN cycle 2 -> all outputs 0 immediately, no done; a following 0x0001+0x0001 -> out=0x0002.
REQ-035 Default parameters (1024/32): in1 = all ones, in2 = 1 -> done after 32 cycles, out=0, carry_out=1; compare 100 random add/sub vectors against a behavioural reference.
